rom_mult_arbiter: RTL

//  Shares one multiplier_ROM lookup port (10-bit address {a,b}, 10-bit product) between N_REQ requesters.

---
 rtl/rom_mult_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/rom_mult_arbiter.sv
// Round-robin arbiter that shares one multiplier ROM lookup port among N_REQ requesters.
// Latency: arbitration edge E -> GNT in cycle E+1 -> RVALID/RDATA in cycle E+2; 1 lookup per 2 cycles.
// Backpressure: requesters hold REQ/operands until GNT; losers wait, and a pending request is served within N_REQ arbitrations.
//
// Ports:
//   CLK, RESET      rising-edge clock, asynchronous active-low reset
//   REQ/OPA/OPB     per-requester level request and packed operands (requester i at [i*OP_W +: OP_W])
//   GNT             registered one-hot grant pulse
//   ROM_A/ROM_Z     registered ROM address {a,b} / combinational ROM product
//   RVALID/RDATA    one-hot result pulse to the winner / product (holds until next capture)
//   BUSY            high while a lookup is in flight (state != IDLE)
module rom_mult_arbiter #(
  parameter int N_REQ  = 4,
  parameter int OP_W   = 5,
  parameter int PROD_W = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [N_REQ*OP_W-1:0] OPA,
  input  logic [N_REQ*OP_W-1:0] OPB,
  output logic [N_REQ-1:0]      GNT,
  output logic [2*OP_W-1:0]     ROM_A,
  input  logic [PROD_W-1:0]     ROM_Z,
  output logic [N_REQ-1:0]      RVALID,
  output logic [PROD_W-1:0]     RDATA,
  output logic                  BUSY
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_win;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_rvalid;
  logic [2*OP_W-1:0] r_rom_a;
  logic [PROD_W-1:0] r_rdata;

  logic              w_win_vld;
  logic [PTR_W-1:0]  w_win_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  w_win_oh;

  // Requester index at round-robin distance off from base, wrapped mod N_REQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PTR_W-1:0];
  endfunction

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (REQ[rr_idx(r_ptr, k)]) begin
        w_win_vld = 1'b1;
        w_win_idx = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
  assign w_win_oh  = N_REQ'(1) << w_win_idx;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rom_a  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_LOOKUP: begin
          // ROM_A has been stable for a full cycle; capture the product for the winner.
          r_gnt    <= '0;
          r_rdata  <= ROM_Z;
          r_rvalid <= N_REQ'(1) << r_win;
          r_state  <= S_RETURN;
        end
        default: begin
          // IDLE and RETURN both arbitrate; from RETURN this gives back-to-back service.
          r_gnt    <= '0;
          r_rvalid <= '0;
          if (w_win_vld) begin
            r_gnt   <= w_win_oh;
            r_rom_a <= {OPA[int'(w_win_idx)*OP_W +: OP_W], OPB[int'(w_win_idx)*OP_W +: OP_W]};
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_idx;
            r_state <= S_LOOKUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign ROM_A  = r_rom_a;
  assign RVALID = r_rvalid;
  assign RDATA  = r_rdata;
  assign BUSY   = (r_state != S_IDLE);

endmodule
